// File: rtl/cacheline_pkg.sv
// Shared types and sizing for the cache-line to burst-memory adaptor.
package cacheline_pkg;
  localparam int LINE_W   = 256;
  localparam int BEAT_W   = 64;
  localparam int BEATS    = 4;
  localparam int OFFSET_W = 5;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
endpackage

// File: rtl/cacheline_adaptor.sv
// Converts one 256-bit cache line request into a 4-beat 64-bit memory burst,
// then returns a single-cycle pmem_resp with the assembled read line.
module cacheline_adaptor #(
  parameter int BEATS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pmem_read,
  input  logic                  pmem_write,
  input  logic [31:0]           pmem_address,
  input  logic [BEATS*64-1:0]   pmem_wdata,
  output logic [BEATS*64-1:0]   pmem_rdata,
  output logic                  pmem_resp,
  output logic                  burst_read,
  output logic                  burst_write,
  output logic [31:0]           burst_address,
  output logic [63:0]           burst_wdata,
  input  logic [63:0]           burst_rdata,
  input  logic                  burst_resp
);
  import cacheline_pkg::*;

  localparam int LW = BEATS * BEAT_W;

  state_t          state, state_nxt;
  logic [1:0]      cnt;
  logic [31:0]     addr_q;
  logic [LW-1:0]   wline, rline;
  logic            last_beat;

  assign last_beat = burst_resp && (cnt == 2'(BEATS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Write has priority when both requests are raised together.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pmem_write)     state_nxt = WRITE;
               else if (pmem_read) state_nxt = READ;
      READ:    if (last_beat)      state_nxt = DONE;
      WRITE:   if (last_beat)      state_nxt = DONE;
      DONE:                        state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      addr_q <= '0;
      wline  <= '0;
      rline  <= '0;
    end else begin
      case (state)
        IDLE: if (pmem_write || pmem_read) begin
          addr_q <= pmem_address;
          cnt    <= '0;
          if (pmem_write) wline <= pmem_wdata;
        end
        READ: if (burst_resp) begin
          rline[cnt*BEAT_W +: BEAT_W] <= burst_rdata;
          cnt <= cnt + 2'd1;
        end
        WRITE: if (burst_resp) cnt <= cnt + 2'd1;
        default: ;
      endcase
    end
  end

  // Outputs decode only registered state, so no pmem_*/burst_* input reaches them combinationally.
  assign burst_read    = (state == READ);
  assign burst_write   = (state == WRITE);
  assign pmem_resp     = (state == DONE);
  assign burst_address = addr_q & ~32'((1 << OFFSET_W) - 1);
  assign burst_wdata   = wline[cnt*BEAT_W +: BEAT_W];
  assign pmem_rdata    = rline;
endmodule

// File: tb/tb_cacheline_adaptor.sv
// Self-checking bench: directed vector table, reset/corner sequences, then random traffic.
module tb_cacheline_adaptor;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         pmem_read, pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata, pmem_rdata;
  logic         pmem_resp;
  logic         burst_read, burst_write;
  logic [31:0]  burst_address;
  logic [63:0]  burst_wdata, burst_rdata;
  logic         burst_resp;

  cacheline_adaptor #(.BEATS(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .burst_read(burst_read), .burst_write(burst_write), .burst_address(burst_address),
    .burst_wdata(burst_wdata), .burst_rdata(burst_rdata), .burst_resp(burst_resp)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  logic [255:0] last_line;  // line pmem_rdata must hold between requests

  typedef struct {
    logic         rd, wr;
    logic [31:0]  addr;
    logic [255:0] wd;
    logic [255:0] line;      // what memory returns on a read
    logic [15:0]  pat;       // burst_resp per cycle, LSB first, 1 once exhausted
    logic         scramble;  // wiggle pmem_* mid-burst
    logic         exp_wr;
    logic [31:0]  exp_baddr;
  } vec_t;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      burst_resp  = 1'b1;
      burst_rdata = {$urandom, $urandom};
      @(posedge clk); #1;
      chk("idle_burst_read", 256'(burst_read), 256'(0));
      chk("idle_burst_write", 256'(burst_write), 256'(0));
      chk("idle_resp", 256'(pmem_resp), 256'(0));
      chk("idle_rdata_stable", pmem_rdata, last_line);
    end
    burst_resp = 1'b0;
  endtask

  task automatic run_txn(input vec_t v, input bit rand_pat);
    int k = 0;
    int i = 0;
    logic r;
    pmem_read = v.rd; pmem_write = v.wr; pmem_address = v.addr; pmem_wdata = v.wd;
    burst_resp = 1'b0;
    @(posedge clk); #1;
    while (k < 4 && i < 200) begin
      chk("burst_read", 256'(burst_read), 256'(!v.exp_wr));
      chk("burst_write", 256'(burst_write), 256'(v.exp_wr));
      chk("resp_early", 256'(pmem_resp), 256'(0));
      chk("burst_address", 256'(burst_address), 256'(v.exp_baddr));
      if (v.exp_wr) chk("burst_wdata", 256'(burst_wdata), 256'(v.wd[64*k +: 64]));
      r = rand_pat ? 1'($urandom_range(0, 1)) : (i < 16 ? v.pat[i] : 1'b1);
      burst_resp  = r;
      burst_rdata = r ? v.line[64*k +: 64] : {$urandom, $urandom};
      if (v.scramble) begin
        pmem_address = $urandom;
        pmem_wdata   = {8{$urandom}};
      end
      @(posedge clk); #1;
      if (r) k++;
      i++;
    end
    chk("beats_accepted", 256'(k), 256'(4));
    chk("resp_pulse", 256'(pmem_resp), 256'(1));
    chk("done_burst_read", 256'(burst_read), 256'(0));
    chk("done_burst_write", 256'(burst_write), 256'(0));
    if (!v.exp_wr) begin
      last_line = v.line;
      chk("rdata_line", pmem_rdata, v.line);
    end else begin
      chk("rdata_kept", pmem_rdata, last_line);
    end
    pmem_read = 1'b0; pmem_write = 1'b0;
    burst_resp = 1'($urandom_range(0, 1));  // spurious in DONE
    @(posedge clk); #1;
    chk("resp_one_cycle", 256'(pmem_resp), 256'(0));
    chk("post_idle_read", 256'(burst_read), 256'(0));
    chk("post_idle_write", 256'(burst_write), 256'(0));
    burst_resp = 1'b0;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_resp", 256'(pmem_resp), 256'(0));
    chk("rst_burst_read", 256'(burst_read), 256'(0));
    chk("rst_burst_write", 256'(burst_write), 256'(0));
    chk("rst_burst_address", 256'(burst_address), 256'(0));
    chk("rst_burst_wdata", 256'(burst_wdata), 256'(0));
    chk("rst_rdata", pmem_rdata, 256'(0));
  endtask

  vec_t tbl[5];
  vec_t rv;

  initial begin
    tbl[0] = '{rd:1, wr:0, addr:32'h0000_1234, wd:'0,
               line:{{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}},
               pat:16'hFFFF, scramble:0, exp_wr:0, exp_baddr:32'h0000_1220};
    tbl[1] = '{rd:0, wr:1, addr:32'h0000_8047,
               wd:256'h0123456789ABCDEF_FEDCBA9876543210_0011223344556677_8899AABBCCDDEEFF,
               line:'0, pat:16'h0059, scramble:0, exp_wr:1, exp_baddr:32'h0000_8040};
    tbl[2] = '{rd:0, wr:1, addr:32'h1000_003F, wd:{8{32'hA5A5_5A5A}},
               line:'0, pat:16'hFFFF, scramble:0, exp_wr:1, exp_baddr:32'h1000_0020};
    tbl[3] = '{rd:1, wr:0, addr:32'hDEAD_BEEF, wd:'0, line:{8{32'h1357_9BDF}},
               pat:16'h00A5, scramble:1, exp_wr:0, exp_baddr:32'hDEAD_BEE0};
    tbl[4] = '{rd:1, wr:1, addr:32'hFFFF_FFFF, wd:{4{64'hCAFE_F00D_0BAD_BEEF}},
               line:{4{64'h1}}, pat:16'hFFFF, scramble:0, exp_wr:1, exp_baddr:32'hFFFF_FFE0};

    rst_n = 1'b0; pmem_read = 0; pmem_write = 0; pmem_address = '0; pmem_wdata = '0;
    burst_rdata = '0; burst_resp = 0; last_line = '0;
    #12;
    chk_reset_outputs();
    @(negedge clk) rst_n = 1'b1;
    idle_cycles(2);

    // Entries 2 and 3 run back to back: write-back immediately followed by refill.
    for (int t = 0; t < 5; t++) begin
      run_txn(tbl[t], 1'b0);
      if (t != 2) idle_cycles(1);
    end

    // Abandon a read after two beats via asynchronous reset.
    pmem_read = 1'b1; pmem_address = 32'h4000_0100;
    @(posedge clk); #1;
    for (int b = 0; b < 2; b++) begin
      burst_resp = 1'b1; burst_rdata = {2{32'hBAD0_0000 | b}};
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs();
    pmem_read = 1'b0; burst_resp = 1'b0; last_line = '0;
    @(negedge clk) rst_n = 1'b1;
    idle_cycles(1);
    rv = '{rd:1, wr:0, addr:32'h4000_0100, wd:'0, line:{8{32'h600D_0001}},
           pat:16'h0033, scramble:0, exp_wr:0, exp_baddr:32'h4000_0100};
    run_txn(rv, 1'b0);

    for (int n = 0; n < 40; n++) begin
      rv.wr = 1'($urandom_range(0, 1));
      rv.rd = rv.wr ? 1'($urandom_range(0, 1)) : 1'b1;
      rv.addr = $urandom;
      for (int j = 0; j < 8; j++) begin
        rv.wd[32*j +: 32]   = $urandom;
        rv.line[32*j +: 32] = $urandom;
      end
      rv.pat = '0;
      rv.scramble = 1'($urandom_range(0, 1));
      rv.exp_wr = rv.wr;
      rv.exp_baddr = {rv.addr[31:5], 5'b0};
      run_txn(rv, 1'b1);
      idle_cycles($urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cacheline_adaptor.md
# cacheline_adaptor

Memory-side responder for the data cache's physical-memory port. Accepts one 256-bit line read or write at a time from the cache controller (pmem_read / pmem_write / pmem_resp handshake). Converts it into a 4-beat, 64-bit burst on the external memory bus, then returns a single-cycle pmem_resp. Sits between dcache and the burst memory model / arbiter.

## Interface
Parameters:
- BEATS, 4, beats per line (fixed; line = BEATS × 64 = 256 bits)

Ports:
- clk  in  1  clock; one clock domain, all logic on posedge
- rst_n  in  1  reset, asynchronous and active-low
- pmem_read  in  1  cache requests line read; held until pmem_resp
- pmem_write  in  1  cache requests line write; held until pmem_resp
- pmem_address  in  32  line address; bits [4:0] ignored
- pmem_wdata  in  256  write line; stable while pmem_write held
- pmem_rdata  out  256  read line; valid in the pmem_resp cycle
- pmem_resp  out  1  one-cycle completion pulse
- burst_read  out  1  memory read burst request
- burst_write  out  1  memory write burst request
- burst_address  out  32  {pmem_address[31:5], 5'b0}
- burst_wdata  out  64  current write beat
- burst_rdata  in  64  current read beat; valid when burst_resp=1
- burst_resp  in  1  beat accepted (write) or delivered (read)

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - pmem_write=1: latch pmem_address and pmem_wdata, clear beat counter, go to WRITE.
  - else pmem_read=1: latch pmem_address, clear counter, go to READ.
  - Both asserted: write wins (protocol violation; behaviour still defined).
- READ: burst_read=1. Each cycle with burst_resp=1:
  - store burst_rdata into line slice [64·k+63:64·k], k = counter;
  - increment counter.
  - Beat k=3 → DONE.
- WRITE: burst_write=1, burst_wdata = latched line slice k. Each cycle with burst_resp=1 increments the counter. Beat k=3 → DONE.
- DONE:
  - pmem_resp=1 for exactly one cycle; pmem_rdata holds the assembled line (after a read; undefined-but-stable after a write).
  - Next state always IDLE; requests are not sampled in DONE.
- Counter: 2 bits, wraps 3→0. It is not the exit condition; exit is keyed on k=3 with burst_resp.
- burst_resp outside READ/WRITE: ignored.
- Request lines are not re-sampled during READ/WRITE. The latched address and data are used throughout, so pmem_* changes mid-burst have no effect.
- All outputs are Moore (decoded from registered state/data); no combinational path from pmem_* or burst_* to any output.

## Timing
- Reset values (async on rst_n low): state IDLE, counter 0, pmem_resp 0, burst_read 0, burst_write 0, burst_address 0, burst_wdata 0, pmem_rdata 0.
- Reset mid-burst: burst request drops immediately (async); the line in progress is abandoned. The memory side must tolerate this.
- Request sampled at edge T in IDLE → burst_read/burst_write high from T+1.
- Fourth burst_resp at edge R → pmem_resp high in cycle R+1, low at R+2.
- Back-to-back beats: one beat per cycle. Gaps (burst_resp=0) stall the counter without limit; no timeout.
- Minimum turnaround: pmem_resp cycle, one IDLE cycle, then the next request is sampled. This matches the dcache write_back→write_cache sequence.
- Latency with zero-wait memory delivering a beat every cycle from T+1: pmem_resp at T+5.

## Structure
- Package cacheline_pkg:
  - state enum typedef;
  - constants LINE_W=256, BEAT_W=64, BEATS=4, OFFSET_W=5.
- Single module; line buffer as a 256-bit register with indexed slice writes. No sub-module needed.

## Test plan
- Read, zero-wait: pmem_read at addr 0x0000_1234; memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on consecutive cycles → burst_address=0x0000_1220; pmem_rdata={44..,33..,22..,11..}; pmem_resp one cycle at T+5.
- Write with stalls: pmem_write, pmem_wdata=256'h0123…CDEF; burst_resp pattern 1,0,0,1,1,0,1 → burst_wdata steps through slices 0..3 only on accepted beats; single pmem_resp after the 4th accept.
- Write-back then refill: pmem_write completes, the cache raises pmem_read in the next cycle → adaptor idles one cycle, then starts the read burst with the new address; no lost or merged request.
- Simultaneous pmem_read and pmem_write in IDLE → write burst only; burst_read stays 0.
- Reset mid-read after 2 beats → outputs return to reset values asynchronously; the next read assembles a fresh line with no stale beats at slices 0/1 visible in the result.
- Spurious burst_resp in IDLE/DONE and pmem_address change mid-burst → no counter change, burst_address stays at the latched value.
